matrix_row_collector: RTL and testbench

MATRIX_ROW_COLLECTOR -- requirements
Module: matrix_row_collector

---
 rtl/matrix_row_collector.sv | 137 +++++++++++++
 tb/tb_matrix_row_collector.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_collector.sv
// Collects ROWS input rows of COLS elements into one row-major matrix for a downstream consumer.
// Define MATRIX_ROW_COLLECTOR_DOUBLE_BUF_EN for a two-bank ping-pong buffer (default: single bank).
module matrix_row_collector #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COLS*DATA_WIDTH-1:0]      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [ROWS*COLS*DATA_WIDTH-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int ROW_W = COLS * DATA_WIDTH;
  localparam int CW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  logic [CW-1:0] row_cnt;
  logic          run;
  logic          accept;
  logic          complete;
  logic          consume;

  assign accept   = in_valid && in_ready;
  assign complete = accept && (row_cnt == LAST_ROW);
  assign consume  = out_valid && out_ready;

  // run holds in_ready low while reset is asserted, since the idle state itself is ready
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        row_cnt <= complete ? '0 : row_cnt + 1'b1;
      end
    end
  end

`ifdef MATRIX_ROW_COLLECTOR_DOUBLE_BUF_EN

  logic [ROW_W-1:0] bank [2][ROWS];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       full_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      full_cnt <= 2'd0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else begin
      if (accept) begin
        bank[wr_ptr][row_cnt] <= in_data;
      end
      if (complete) begin
        wr_ptr <= ~wr_ptr;
      end
      if (consume) begin
        rd_ptr <= ~rd_ptr;
      end
      // simultaneous completion and consume leaves the occupancy unchanged
      case ({complete, consume})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

  assign in_ready  = run && (full_cnt != 2'd2);
  assign out_valid = (full_cnt != 2'd0);

  always_comb begin
    out_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      out_data[r*ROW_W +: ROW_W] = bank[rd_ptr][r];
    end
  end

`else

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ROW_W-1:0] bank [ROWS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      for (int r = 0; r < ROWS; r++) begin
        bank[r] <= '0;
      end
    end else begin
      state <= state_next;
      if (accept) begin
        bank[row_cnt] <= in_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (complete) state_next = FULL;
      FULL:    if (consume)  state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  assign in_ready  = run && (state == FILL);
  assign out_valid = (state == FULL);

  always_comb begin
    out_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      out_data[r*ROW_W +: ROW_W] = bank[r];
    end
  end

`endif

endmodule

// File: tb/tb_matrix_row_collector.sv
// Scoreboard bench for matrix_row_collector (ROWS=2, COLS=2, DATA_WIDTH=8).
// Double-buffer checks are built when MATRIX_ROW_COLLECTOR_DOUBLE_BUF_EN is defined.
module tb_matrix_row_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int passed = 0;
  logic [31:0] sb [$];

  matrix_row_collector #(
    .ROWS       (2),
    .COLS       (2),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // monitor: a matrix is consumed at the next rising edge whenever valid&&ready is seen here
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_matrix: got 0x%0h, expected no output at %0t", out_data, $time);
      end else begin
        check("matrix", out_data, sb.pop_front());
      end
    end
  end

  task automatic send_row(input logic [7:0] e0, input logic [7:0] e1);
    int n = 0;
    in_data  = {e1, e0};
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((out_valid !== 1'b0 || sb.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 32'(n < 50), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // back-to-back rows, downstream always ready
    out_ready = 1'b1;
    sb.push_back(32'h04030201);
    send_row(8'h01, 8'h02);
    check("partial_no_valid", 32'(out_valid), 32'd0);
    send_row(8'h03, 8'h04);
    check("latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("consumed", 32'(out_valid), 32'd0);

    // downstream stall
    out_ready = 1'b0;
    sb.push_back(32'h24232221);
`ifdef MATRIX_ROW_COLLECTOR_DOUBLE_BUF_EN
    sb.push_back(32'h08070605);
`endif
    send_row(8'h21, 8'h22);
    send_row(8'h23, 8'h24);
    check("stall_valid0", 32'(out_valid), 32'd1);
`ifdef MATRIX_ROW_COLLECTOR_DOUBLE_BUF_EN
    send_row(8'h05, 8'h06);
    send_row(8'h07, 8'h08);
    for (int i = 0; i < 3; i++) begin
      check("stall_ready_db", 32'(in_ready), 32'd0);
      check("stall_data_db", out_data, 32'h24232221);
      @(posedge clk); #1;
    end
`else
    in_data  = 16'h0605;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, 32'h24232221);
      check("stall_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
`endif
    drain();

    // in_valid every other cycle
    sb.push_back(32'h44332211);
    send_row(8'h11, 8'h22);
    @(posedge clk); #1;
    send_row(8'h33, 8'h44);
    @(posedge clk); #1;
    drain();

    // reset after a partial matrix discards it
    out_ready = 1'b0;
    send_row(8'hAA, 8'hBB);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    sb.push_back(32'h0C0B0A09);
    send_row(8'h09, 8'h0A);
    send_row(8'h0B, 8'h0C);
    drain();

    // opaque bit patterns
    sb.push_back(32'h007FFF80);
    send_row(8'h80, 8'hFF);
    send_row(8'h7F, 8'h00);
    drain();

`ifdef MATRIX_ROW_COLLECTOR_DOUBLE_BUF_EN
    // completion and consume on the same edge
    out_ready = 1'b0;
    sb.push_back(32'h34333231);
    sb.push_back(32'h44434241);
    send_row(8'h31, 8'h32);
    send_row(8'h33, 8'h34);
    send_row(8'h41, 8'h42);
    in_data   = 16'h4443;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("same_edge_valid", 32'(out_valid), 32'd1);
    check("same_edge_data", out_data, 32'h44434241);
    check("same_edge_ready", 32'(in_ready), 32'd1);
    drain();
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
